// File: rtl/rcc_rsr_pkg.sv
// Shared definitions for the RCC reset-status flag generator: source indices,
// LSI handshake states and index helpers.
package rcc_rsr_pkg;

  localparam int unsigned SRC_LPWR2 = 0;
  localparam int unsigned SRC_LPWR1 = 1;
  localparam int unsigned SRC_WWDG2 = 2;
  localparam int unsigned SRC_WWDG1 = 3;
  localparam int unsigned SRC_IWDG2 = 4;
  localparam int unsigned SRC_IWDG1 = 5;
  localparam int unsigned SRC_SFT2  = 6;
  localparam int unsigned SRC_POR   = 7;
  localparam int unsigned SRC_SFT1  = 8;
  localparam int unsigned SRC_BOR   = 9;
  localparam int unsigned SRC_PIN   = 10;
  localparam int unsigned SRC_D2    = 11;
  localparam int unsigned SRC_OBL   = 12;

  localparam logic [4:0]  CAUSE_NONE            = 5'h1F;
  localparam logic [12:0] RST_FLAG_MASK_DEFAULT = 13'h0280;

  typedef enum logic [1:0] {
    LSI_OFF,
    LSI_START,
    LSI_RDY
  } lsi_state_e;

  function automatic logic [4:0] highest_set_idx(input logic [31:0] v);
    logic [4:0] idx;
    idx = CAUSE_NONE;
    for (int unsigned i = 0; i < 32; i++) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  function automatic logic [4:0] lowest_set_idx(input logic [31:0] v);
    logic [4:0] idx;
    idx = CAUSE_NONE;
    for (int unsigned i = 32; i > 0; i--) begin
      if (v[i-1]) idx = 5'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rcc_rsr_flags_gen_cpu_view.sv
// One CPU's view of the reset status: sticky flags, RMVF control bit and the
// index of the most recently captured reset source.
module rcc_rsr_cpu_view
  import rcc_rsr_pkg::*;
#(
  parameter int unsigned          NUM_SRC       = 13,
  parameter logic [NUM_SRC-1:0]   RST_FLAG_MASK = NUM_SRC'(RST_FLAG_MASK_DEFAULT)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [NUM_SRC-1:0] evt_i,
  input  logic               rmvf_wren_i,
  input  logic               wdata_i,
  output logic [NUM_SRC-1:0] flags_o,
  output logic               rmvf_o,
  output logic [4:0]         cause_o
);

  localparam logic [4:0] RST_CAUSE = lowest_set_idx(32'(RST_FLAG_MASK));

  logic [NUM_SRC-1:0] flags_q, flags_d;
  logic               rmvf_q, rmvf_d;
  logic [4:0]         cause_q, cause_d;
  logic               clr;

  // A write of 1 wins over an event in the same cycle, so the clear takes
  // effect on the write edge rather than one cycle later.
  always_comb begin
    clr     = rmvf_q | (rmvf_wren_i & wdata_i);
    rmvf_d  = rmvf_wren_i ? wdata_i : rmvf_q;
    flags_d = flags_q | evt_i;
    cause_d = cause_q;
    if (clr) begin
      flags_d = '0;
      cause_d = CAUSE_NONE;
    end else if (|evt_i) begin
      cause_d = highest_set_idx(32'(evt_i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      flags_q <= RST_FLAG_MASK;
      rmvf_q  <= 1'b0;
      cause_q <= RST_CAUSE;
    end else begin
      flags_q <= flags_d;
      rmvf_q  <= rmvf_d;
      cause_q <= cause_d;
    end
  end

  assign flags_o = flags_q;
  assign rmvf_o  = rmvf_q;
  assign cause_o = cause_q;

endmodule

// File: rtl/rcc_rsr_flags_gen.sv
// Reset-status flag generator: synchronises and edge-detects reset sources,
// fans the events out to per-CPU views, and runs the LSI enable/ready handshake.
module rcc_rsr_flags_gen
  import rcc_rsr_pkg::*;
#(
  parameter int unsigned        NUM_CPU       = 2,
  parameter int unsigned        NUM_SRC       = 13,
  parameter logic [NUM_SRC-1:0] RST_FLAG_MASK = NUM_SRC'(RST_FLAG_MASK_DEFAULT),
  parameter int unsigned        LSI_STARTUP   = 16,
  parameter int unsigned        SYNC_STAGES   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         rst_src,
  input  logic [NUM_CPU-1:0]         rmvf_wren,
  input  logic                       lsion_wren,
  input  logic                       wdata,
  output logic [NUM_CPU*NUM_SRC-1:0] rsr_flags,
  output logic [NUM_CPU-1:0]         rsr_rmvf,
  output logic [NUM_CPU*5-1:0]       last_cause,
  output logic                       lsion,
  output logic                       lsirdy
);

  localparam int unsigned      CNT_W    = $clog2(LSI_STARTUP + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LSI_STARTUP - 1);

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
  logic [NUM_SRC-1:0]                  prev_q;
  logic [NUM_SRC-1:0]                  evt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rst_src};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign evt = sync_q[SYNC_STAGES-1] & ~prev_q;

  for (genvar c = 0; c < NUM_CPU; c++) begin : g_cpu
    rcc_rsr_cpu_view #(
      .NUM_SRC       (NUM_SRC),
      .RST_FLAG_MASK (RST_FLAG_MASK)
    ) u_view (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .evt_i       (evt),
      .rmvf_wren_i (rmvf_wren[c]),
      .wdata_i     (wdata),
      .flags_o     (rsr_flags[c*NUM_SRC +: NUM_SRC]),
      .rmvf_o      (rsr_rmvf[c]),
      .cause_o     (last_cause[c*5 +: 5])
    );
  end

  lsi_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lsion_q, lsirdy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LSI_OFF: begin
        if (lsion_wren && wdata) begin
          state_d = LSI_START;
          cnt_d   = '0;
        end
      end
      LSI_START: begin
        if (lsion_wren && !wdata) begin
          state_d = LSI_OFF;
          cnt_d   = '0;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = LSI_RDY;
        end
      end
      LSI_RDY: begin
        if (lsion_wren && !wdata) begin
          state_d = LSI_OFF;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = LSI_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= LSI_OFF;
      cnt_q    <= '0;
      lsion_q  <= 1'b0;
      lsirdy_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lsion_q  <= (state_d != LSI_OFF);
      lsirdy_q <= (state_d == LSI_RDY);
    end
  end

  assign lsion  = lsion_q;
  assign lsirdy = lsirdy_q;

endmodule

// File: tb/tb_rcc_rsr_flags_gen.sv
// Scoreboard bench: two configurations (default and 4 CPU / 32 source / 3-stage
// sync) driven by shared stimulus and checked against a cycle-level model.
module tb_rcc_rsr_flags_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rst_src;
  logic [3:0]  rmvf_wren;
  logic        lsion_wren;
  logic        wdata;

  logic [25:0]  a_flags;
  logic [1:0]   a_rmvf;
  logic [9:0]   a_cause;
  logic         a_lsion, a_lsirdy;
  logic [127:0] b_flags;
  logic [3:0]   b_rmvf;
  logic [19:0]  b_cause;
  logic         b_lsion, b_lsirdy;

  always #5 clk = ~clk;

  rcc_rsr_flags_gen dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_src    (rst_src[12:0]),
    .rmvf_wren  (rmvf_wren[1:0]),
    .lsion_wren (lsion_wren),
    .wdata      (wdata),
    .rsr_flags  (a_flags),
    .rsr_rmvf   (a_rmvf),
    .last_cause (a_cause),
    .lsion      (a_lsion),
    .lsirdy     (a_lsirdy)
  );

  rcc_rsr_flags_gen #(
    .NUM_CPU       (4),
    .NUM_SRC       (32),
    .RST_FLAG_MASK (32'h0000_0280),
    .LSI_STARTUP   (16),
    .SYNC_STAGES   (3)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_src    (rst_src),
    .rmvf_wren  (rmvf_wren),
    .lsion_wren (lsion_wren),
    .wdata      (wdata),
    .rsr_flags  (b_flags),
    .rsr_rmvf   (b_rmvf),
    .last_cause (b_cause),
    .lsion      (b_lsion),
    .lsirdy     (b_lsirdy)
  );

  typedef struct packed {
    logic [127:0] flags;
    logic [3:0]   rmvf;
    logic [19:0]  cause;
    logic         lsion;
    logic         lsirdy;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks   = 0;
  int   failures = 0;

  // Model state, index 0 = default config, 1 = wide config.
  logic [31:0] hist   [2][5];
  logic [31:0] mflags [2][4];
  logic        mrmvf  [2][4];
  logic [4:0]  mcause [2][4];
  bit          lon    [2];
  int          lage   [2];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input int d, output exp_t e);
    int          nc, ns, s;
    logic [31:0] smask, evt;
    nc    = (d == 0) ? 2 : 4;
    ns    = (d == 0) ? 13 : 32;
    s     = (d == 0) ? 2 : 3;
    smask = (d == 0) ? 32'h0000_1FFF : 32'hFFFF_FFFF;
    if (!rst_n) begin
      for (int k = 0; k < 5; k++) hist[d][k] = '0;
      for (int c = 0; c < 4; c++) begin
        mflags[d][c] = 32'h0280;
        mrmvf[d][c]  = 1'b0;
        mcause[d][c] = 5'd7;
      end
      lon[d]  = 1'b0;
      lage[d] = 0;
    end else begin
      // Synchronised level seen this cycle is the raw sample from s edges ago.
      evt = hist[d][s-1] & ~hist[d][s];
      for (int k = 4; k > 0; k--) hist[d][k] = hist[d][k-1];
      hist[d][0] = rst_src & smask;
      for (int c = 0; c < nc; c++) begin
        if (mrmvf[d][c] || (rmvf_wren[c] && wdata)) begin
          mflags[d][c] = '0;
          mcause[d][c] = 5'h1F;
        end else begin
          mflags[d][c] = mflags[d][c] | evt;
          for (int i = 0; i < 32; i++) if (evt[i]) mcause[d][c] = 5'(i);
        end
        if (rmvf_wren[c]) mrmvf[d][c] = wdata;
      end
      if (lsion_wren && !wdata) lon[d] = 1'b0;
      else if (lon[d]) lage[d]++;
      else if (lsion_wren && wdata) begin
        lon[d]  = 1'b1;
        lage[d] = 0;
      end
    end
    e = '0;
    for (int c = 0; c < nc; c++) begin
      for (int i = 0; i < ns; i++) e.flags[c*ns+i] = mflags[d][c][i];
      e.rmvf[c]        = mrmvf[d][c];
      e.cause[c*5 +: 5] = mcause[d][c];
    end
    e.lsion  = lon[d];
    e.lsirdy = lon[d] && (lage[d] >= 16);
  endtask

  task automatic tick();
    exp_t ea, eb;
    @(posedge clk);
    model_edge(0, ea);
    qa.push_back(ea);
    model_edge(1, eb);
    qb.push_back(eb);
    #1;
    rmvf_wren  = '0;
    lsion_wren = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_flags",  128'(a_flags),  e.flags);
        chk("a_rmvf",   128'(a_rmvf),   128'(e.rmvf));
        chk("a_cause",  128'(a_cause),  128'(e.cause));
        chk("a_lsion",  128'(a_lsion),  128'(e.lsion));
        chk("a_lsirdy", 128'(a_lsirdy), 128'(e.lsirdy));
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_flags",  b_flags,        e.flags);
        chk("b_rmvf",   128'(b_rmvf),   128'(e.rmvf));
        chk("b_cause",  128'(b_cause),  128'(e.cause));
        chk("b_lsion",  128'(b_lsion),  128'(e.lsion));
        chk("b_lsirdy", 128'(b_lsirdy), 128'(e.lsirdy));
      end
    end
  end

  // Counts edges from the enabling write to lsirdy, optionally rewriting 1.
  task automatic measure_lsi(input int rewrite_at, input string nm);
    int n, na, nb;
    n  = 0;
    na = -1;
    nb = -1;
    lsion_wren = 1'b1;
    wdata      = 1'b1;
    tick();
    while ((na < 0 || nb < 0) && n < 40) begin
      if (n == rewrite_at) begin
        lsion_wren = 1'b1;
        wdata      = 1'b1;
      end
      tick();
      n++;
      if (na < 0 && a_lsirdy === 1'b1) na = n;
      if (nb < 0 && b_lsirdy === 1'b1) nb = n;
    end
    chk({nm, "_a"}, 128'(na), 128'(16));
    chk({nm, "_b"}, 128'(nb), 128'(16));
  endtask

  initial begin
    logic [25:0] rst_pair;
    rst_n      = 1'b0;
    rst_src    = '0;
    rmvf_wren  = '0;
    lsion_wren = 1'b0;
    wdata      = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    rst_pair = {13'h0280, 13'h0280};
    chk("rst_flags_a", 128'(a_flags), 128'(rst_pair));
    chk("rst_cause_a", 128'(a_cause), 128'({5'd7, 5'd7}));

    rst_src[3] = 1'b1;
    tick();
    tick();
    chk("bit3_early_a", 128'({a_flags[16], a_flags[3]}), 128'(0));
    tick();
    chk("bit3_lat3_a", 128'({a_flags[16], a_flags[3]}), 128'(2'b11));
    chk("bit3_early_b", 128'(b_flags[3]), 128'(0));
    tick();
    chk("bit3_lat4_b", 128'({b_flags[99], b_flags[67], b_flags[35], b_flags[3]}), 128'(4'hF));
    repeat (6) tick();
    rst_src[3] = 1'b0;
    repeat (4) tick();

    rmvf_wren = 4'b0001;
    wdata     = 1'b1;
    tick();
    for (int k = 0; k < 12; k++) begin
      rst_src[5] = k[1];
      tick();
    end
    chk("hold_flags_a", 128'(a_flags[12:0]), 128'(0));
    chk("hold_cause_a", 128'(a_cause[4:0]), 128'(5'h1F));
    rmvf_wren = 4'b0001;
    wdata     = 1'b0;
    tick();
    repeat (4) tick();

    rst_src[4] = 1'b1;
    tick();
    tick();
    rmvf_wren = 4'b0010;
    wdata     = 1'b1;
    tick();
    chk("collide_cpu1_a", 128'(a_flags[17]), 128'(0));
    chk("collide_cpu0_a", 128'(a_flags[4]), 128'(1));
    rmvf_wren = 4'b0010;
    wdata     = 1'b0;
    tick();
    repeat (3) tick();

    measure_lsi(8, "lsi_latency");
    repeat (3) tick();
    lsion_wren = 1'b1;
    wdata      = 1'b0;
    tick();
    chk("lsi_off_a", 128'({a_lsion, a_lsirdy}), 128'(0));

    lsion_wren = 1'b1;
    wdata      = 1'b1;
    tick();
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("lsi_abort_a", 128'({a_lsion, a_lsirdy}), 128'(0));
    measure_lsi(-1, "lsi_after_abort");
    lsion_wren = 1'b1;
    wdata      = 1'b0;
    tick();

    repeat (3000) begin
      rst_n      = ($urandom_range(0, 199) != 0);
      rst_src    = rst_src ^ ($urandom & $urandom & $urandom);
      rmvf_wren  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
      lsion_wren = ($urandom_range(0, 29) == 0);
      wdata      = 1'($urandom);
      tick();
    end
    rst_n = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    #1;
    chk("queue_drained", 128'(qa.size() + qb.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rcc_rsr_flags_gen.md
Name: rcc_rsr_flags_gen

Overview:
Parametrised next-generation reset-status block for the RCC VDD domain. It replaces the fixed two-CPU, 13-source reset-flag register with N CPU views and M reset sources. Added behaviour: input synchronisation, rising-edge capture, a per-CPU last-cause index, and an LSI enable/ready handshake with startup counter. Sits under rcc_vdd_top, clocked in the VDD domain; level shifting and isolation are added at integration.

Parameters:
NUM_CPU, 2, number of per-CPU RSR views (1..4)
NUM_SRC, 13, number of reset sources (1..32)
RST_FLAG_MASK, 13'h0280, flag bits that read 1 after block reset (POR/BOR positions)
LSI_STARTUP, 16, cycles from LSION=1 to LSIRDY=1 (>=2)
SYNC_STAGES, 2, synchroniser depth on reset-source inputs (>=2)

Ports:
clk  in  1  VDD-domain clock (test mux applied upstream)
rst_n  in  1  synchronous active-low reset, sampled on rising clk; driven from ~pwr_por_rst
rst_src  in  NUM_SRC  raw reset-source levels, async, active-high
rmvf_wren  in  NUM_CPU  per-CPU RMVF write strobe, 1 cycle
lsion_wren  in  1  LSION write strobe, 1 cycle
wdata  in  1  write data for either strobe
rsr_flags  out  NUM_CPU*NUM_SRC  sticky flags; CPU c occupies bits [c*NUM_SRC +: NUM_SRC]
rsr_rmvf  out  NUM_CPU  per-CPU RMVF bit
last_cause  out  NUM_CPU*5  index of the most recent source captured per CPU; 5'h1F = none
lsion  out  1  LSI oscillator enable
lsirdy  out  1  LSI ready

Behaviour:
- Reset is synchronous and active-low. When rst_n=0 at a clk edge: every CPU's flags = RST_FLAG_MASK; rsr_rmvf=0; last_cause = lowest set bit index of RST_FLAG_MASK (5'h1F if the mask is 0); lsion=0; lsirdy=0; LSI counter=0; synchroniser and edge registers = 0.
- Synchronisation: each rst_src bit passes through SYNC_STAGES flops, then an edge register. evt[i] = sync[i] & ~prev[i]. A held level produces exactly one event.
- Flag latency: a source edge sets the flag SYNC_STAGES+1 cycles after the raw rise (3 cycles with the default).
- Flag update per CPU c, per cycle, in priority order:
  1. rsr_rmvf[c]=1: all flags of c are held at 0 and events are ignored.
  2. Otherwise flags |= evt.
- last_cause[c]:
  - When rsr_rmvf[c]=0 and evt is non-zero, it takes the highest set index of evt.
  - When rsr_rmvf[c]=1, it becomes 5'h1F.
- RMVF: on rmvf_wren[c], rsr_rmvf[c] <= wdata. Write 1 clears flags on the next edge and holds them cleared. Write 0 releases them; events in the write-0 cycle are captured from the following cycle.
- Simultaneous rmvf_wren[c] with wdata=1 and an event: the event is lost for that CPU only. Other CPUs are unaffected.
- LSI FSM states: OFF, START, RDY.
  - OFF: lsion=0, lsirdy=0. lsion_wren&wdata moves to START with counter=0.
  - START: lsion=1. The counter increments each cycle. At counter==LSI_STARTUP-1 the FSM moves to RDY. lsion_wren&~wdata moves to OFF.
  - RDY: lsion=1, lsirdy=1. lsion_wren&~wdata moves to OFF, and lsirdy drops on the same edge as lsion.
  - A rewrite of 1 in START or RDY has no effect and does not restart the counter.
- lsirdy rises exactly LSI_STARTUP cycles after the edge that set lsion.
- Counter width is $clog2(LSI_STARTUP+1); the counter saturates and never wraps.
- rst_n=0 mid-START aborts to OFF.
- All outputs are registered; there are no combinational paths from input to output.

Decomposition:
- Package rcc_rsr_pkg holds:
  - source index localparams (SRC_LPWR2=0 … SRC_OBL=12, SRC_POR, SRC_BOR)
  - LSI state typedef {OFF, START, RDY}
  - CAUSE_NONE=5'h1F
  - default RST_FLAG_MASK
- One sub-module, rcc_rsr_cpu_view, instantiated NUM_CPU times by generate. It contains the flags, RMVF and last_cause for one CPU.
- The synchroniser, edge detection and LSI FSM stay in the top.

Test Plan:
- Reset release with defaults -> each CPU's flags=13'h0280, rsr_rmvf=0, last_cause=7, lsion=0, lsirdy=0.
- Pulse rst_src[3] high for 10 cycles -> bit 3 set in both CPUs exactly 3 cycles after the rise, set once; last_cause=3 for both CPUs; flag stays set after the source falls.
- CPU0 writes rmvf=1 then rmvf=0 while rst_src[5] toggles during the hold -> CPU0 flags=0 and last_cause=5'h1F during the hold, rst_src[5] edges ignored; CPU1 still shows bit 5 and last_cause=5.
- rmvf_wren[1]=1 with wdata=1 in the same cycle as a bit-4 event -> CPU1 bit 4 stays 0; CPU0 bit 4 is 1.
- Write lsion=1 -> lsion=1 on the next edge, lsirdy=1 exactly 16 cycles after that edge; rewrite 1 at cycle 8 -> no change to the count; write 0 -> both outputs 0 on the next edge.
- Assert rst_n=0 in START at count 9 -> OFF, counter 0; a later lsion=1 write -> lsirdy after a full 16 cycles. Re-run the suite with NUM_CPU=4, NUM_SRC=32, SYNC_STAGES=3 -> 4-cycle flag latency and independent CPU views.
